// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the block data memory.
// Also used by the dcache bench for the default access latency.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BLOCK_BYTES     = 4;
  localparam int BYTE_W          = 8;
  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 5;

endpackage

// File: rtl/data_memory.sv
// Slow block-addressed main memory behind the data cache.
// One 4-byte block per request, fixed latency, busywait handshake.
module data_memory
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              busywait,
  output logic              err
);

  localparam int DEPTH = BLOCK_BYTES * (2 ** ADDR_W);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wr;
  logic [31:0]       lat_data;
  logic [BYTE_W-1:0] mem [DEPTH];

  logic              req;
  logic [ADDR_W+1:0] b0, b1, b2, b3;

  assign req = read ^ write;
  assign b0  = {lat_addr, 2'd0};
  assign b1  = {lat_addr, 2'd1};
  assign b2  = {lat_addr, 2'd2};
  assign b3  = {lat_addr, 2'd3};

  always_comb begin
    state_nxt = state;
    busywait  = 1'b0;
    unique case (state)
      IDLE: begin
        busywait = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset overrides any request seen in the same cycle
    if (reset) busywait = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      lat_data <= '0;
      readdata <= '0;
      err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= address;
            lat_wr   <= write;
            lat_data <= writedata;
            cnt      <= CNT_W'(LATENCY - 1);
          end
          if (read && write) err <= 1'b1;
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (lat_wr) begin
            mem[b0] <= lat_data[31:24];
            mem[b1] <= lat_data[23:16];
            mem[b2] <= lat_data[15:8];
            mem[b3] <= lat_data[7:0];
          end else begin
            readdata <= {mem[b0], mem[b1], mem[b2], mem[b3]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed table, hand sequences,
// and random accesses against a byte-array reference model.
module tb_data_memory;
  import dmem_pkg::*;

  localparam int LAT = DEFAULT_LATENCY;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          busywait;
  logic          err;

  data_memory #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .busywait(busywait), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rd;
  logic        exp_err;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    int          drop;
    bit          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_rd  = 32'h0;
    exp_err = 1'b0;
  endtask

  function automatic logic [31:0] model_block(input logic [5:0] a);
    int b;
    b = int'(a) * 4;
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One full access; leaves the request asserted through DONE when hold=1
  task automatic access(input bit wr, input logic [5:0] a,
                        input logic [31:0] d, input int drop,
                        input bit hold);
    int hi;
    @(negedge clk);
    read      = !wr;
    write     = wr;
    address   = a;
    writedata = d;
    #1;
    check("busywait_on_request", 32'(busywait), 32'd1);
    hi = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == drop) begin
        read  = 1'b0;
        write = 1'b0;
        address   = ~a;
        writedata = ~d;
      end
      #1;
      if (!busywait) break;
      hi++;
    end
    check("busy_cycles", 32'(hi), 32'(LAT + 1));
    if (wr) begin
      for (int k = 0; k < 4; k++)
        ref_mem[int'(a) * 4 + k] = d[31 - 8*k -: 8];
    end else begin
      exp_rd = model_block(a);
    end
    check(wr ? "readdata_after_write" : "readdata_done", readdata, exp_rd);
    check("err_sticky", 32'(err), 32'(exp_err));
    if (!hold) begin
      read  = 1'b0;
      write = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    reset = 1'b1;
    read  = 1'b1;
    #1;
    check("busywait_in_reset", 32'(busywait), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    read  = 1'b0;
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busywait", 32'(busywait), 32'd0);

    // Directed table
    vecs[0] = '{1'b0, 6'h0A, 32'h0,        0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 6'h03, 32'hDEADBEEF, 0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 6'h03, 32'h0,        0, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 6'h11, 32'h12345678, 0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 6'h21, 32'h0,        0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 6'h11, 32'h0,        0, 1'b0, 32'h12345678};
    vecs[6] = '{1'b1, 6'h05, 32'hCAFEF00D, 2, 1'b0, 32'h12345678};
    vecs[7] = '{1'b0, 6'h05, 32'h0,        0, 1'b0, 32'hCAFEF00D};
    for (int i = 0; i < 8; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].drop, vecs[i].hold);
      check($sformatf("table_rd[%0d]", i), readdata, vecs[i].exp);
      if (i == 1) begin
        check("peek_byte12", 32'(dut.mem[12]), 32'h0000_00DE);
        check("peek_byte15", 32'(dut.mem[15]), 32'h0000_00EF);
      end
    end

    // DONE lasts one cycle, then idle with no request
    @(negedge clk);
    #1;
    check("idle_after_done", 32'(busywait), 32'd0);

    // Illegal simultaneous request
    @(negedge clk);
    read  = 1'b1;
    write = 1'b1;
    address = 6'h2A;
    #1;
    check("illegal_busywait", 32'(busywait), 32'd0);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    #1;
    exp_err = 1'b1;
    check("illegal_err_set", 32'(err), 32'd1);
    check("illegal_no_access", 32'(busywait), 32'd0);

    // Random traffic against the model; err must stay set throughout
    for (int i = 0; i < 60; i++) begin
      logic [5:0] ra;
      ra = 6'($urandom_range(0, 63));
      access(bit'($urandom_range(0, 1)), ra, $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0,
             bit'($urandom_range(0, 1)));
    end
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;

    // Reset during an in-flight write aborts it and clears err
    @(negedge clk);
    write     = 1'b1;
    read      = 1'b0;
    address   = 6'h07;
    writedata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    write = 1'b0;
    #1;
    check("busywait_reset_mid", 32'(busywait), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("err_cleared", 32'(err), 32'd0);
    check("readdata_cleared", readdata, 32'h0);
    check("idle_after_reset", 32'(busywait), 32'd0);
    access(1'b0, 6'h07, 32'h0, 0, 1'b0);
    check("aborted_write", readdata, 32'h0);
    access(1'b0, 6'h03, 32'h0, 0, 1'b0);
    check("storage_cleared", readdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
